// File: rtl/reflet_mem_arbiter.sv
// reflet_mem_arbiter: shares one synchronous RAM port between the CPU address
// unit (master 0) and a secondary requester (master 1). Round-robin arbitration
// with a burst limit so that neither master can starve the other. Grants come
// from registered state only; RAM-side signals are muxed from the granted master.
module reflet_mem_arbiter #(
  parameter int wordsize  = 16,
  parameter int max_burst = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic [wordsize-1:0] m0_addr,
  input  logic [wordsize-1:0] m0_wdata,
  input  logic                m0_we,
  output logic                m0_gnt,
  output logic [wordsize-1:0] m0_rdata,
  output logic                m0_rvalid,
  input  logic                m1_req,
  input  logic [wordsize-1:0] m1_addr,
  input  logic [wordsize-1:0] m1_wdata,
  input  logic                m1_we,
  output logic                m1_gnt,
  output logic [wordsize-1:0] m1_rdata,
  output logic                m1_rvalid,
  output logic [wordsize-1:0] ram_addr,
  output logic [wordsize-1:0] ram_data_out,
  input  logic [wordsize-1:0] ram_data_in,
  output logic                ram_write_en
);

  // Burst limiting is disabled entirely when max_burst is 0; the counter then
  // just saturates at its maximum and never forces a handover.
  localparam logic       LIMITED = (max_burst != 0);
  localparam logic [7:0] LAST    = (max_burst == 0) ? 8'hFF : 8'(max_burst - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic       r_last;
  logic       w_nextLast;
  logic [7:0] r_burstCnt;
  logic       r_rvalid0;
  logic       r_rvalid1;
  logic       w_acc0;
  logic       w_acc1;
  logic       w_limit;

  assign m0_gnt    = (r_state == G0);
  assign m1_gnt    = (r_state == G1);
  assign w_acc0    = m0_gnt && m0_req;
  assign w_acc1    = m1_gnt && m1_req;
  assign w_limit   = LIMITED && (r_burstCnt == LAST);

  assign m0_rdata  = ram_data_in;
  assign m1_rdata  = ram_data_in;
  assign m0_rvalid = r_rvalid0;
  assign m1_rvalid = r_rvalid1;

  // Route the granted master's access to the RAM; drive zeros when nobody accesses.
  always_comb begin
    ram_addr     = '0;
    ram_data_out = '0;
    ram_write_en = 1'b0;
    if (w_acc0) begin
      ram_addr     = m0_addr;
      ram_data_out = m0_wdata;
      ram_write_en = m0_we;
    end else if (w_acc1) begin
      ram_addr     = m1_addr;
      ram_data_out = m1_wdata;
      ram_write_en = m1_we;
    end
  end

  // Next grant: round-robin tie break from IDLE, direct handover with no bubble.
  always_comb begin
    w_nextState = r_state;
    w_nextLast  = r_last;
    case (r_state)
      IDLE: begin
        if (m0_req && m1_req) begin
          w_nextState = r_last ? G0 : G1;
        end else if (m0_req) begin
          w_nextState = G0;
        end else if (m1_req) begin
          w_nextState = G1;
        end
      end
      G0: begin
        if (!m0_req) begin
          w_nextState = m1_req ? G1 : IDLE;
          w_nextLast  = 1'b0;
        end else if (m1_req && w_limit) begin
          w_nextState = G1;
          w_nextLast  = 1'b0;
        end
      end
      G1: begin
        if (!m1_req) begin
          w_nextState = m0_req ? G0 : IDLE;
          w_nextLast  = 1'b1;
        end else if (m0_req && w_limit) begin
          w_nextState = G0;
          w_nextLast  = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State and round-robin history; last starts at 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_nextState;
      r_last  <= w_nextLast;
    end
  end

  // Count accesses within the current grant; restart on any grant change, saturate at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_burstCnt <= 8'd0;
    end else if (w_nextState != r_state) begin
      r_burstCnt <= 8'd0;
    end else if ((w_acc0 || w_acc1) && (r_burstCnt != LAST)) begin
      r_burstCnt <= r_burstCnt + 8'd1;
    end
  end

  // Flag a read's data one cycle later to the master that issued it, even across a grant switch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_acc0 && !m0_we;
      r_rvalid1 <= w_acc1 && !m1_we;
    end
  end

endmodule
